// File: rtl/code_pkg.sv
// code_pkg: character codes and reset message shared by the scroller and the digit decoders.
package code_pkg;
  localparam logic [1:0] CODE_D     = 2'b00;
  localparam logic [1:0] CODE_E     = 2'b01;
  localparam logic [1:0] CODE_ONE   = 2'b10;
  localparam logic [1:0] CODE_BLANK = 2'b11;
  localparam int MAX_DIGITS = 32;
  // "dE1" on digits 3..1, blank elsewhere; the caller keeps the low 2*n bits
  function automatic logic [2*MAX_DIGITS-1:0] reset_msg(input int n);
    logic [2*MAX_DIGITS-1:0] m;
    m = '1;
    for (int i = 0; i < n && i < MAX_DIGITS; i++)
      m[2*i +: 2] = i == 3 ? CODE_D : i == 2 ? CODE_E : i == 1 ? CODE_ONE : CODE_BLANK;
    return m;
  endfunction
endpackage

// File: rtl/rate_divider.sv
// rate_divider: down-counter producing one registered tick every TICKS enabled cycles.
module rate_divider #(
  parameter int TICKS = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic step
);
  localparam int W = TICKS > 1 ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] TOP = W'(TICKS - 1);
  logic [W-1:0] r_count;
  logic         r_tick;
  // step is the combinational "rotate on this edge" strobe; tick is its registered echo
  assign step = en & ~clr & (r_count == '0);
  assign tick = r_tick;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_count <= TOP;
      r_tick  <= 1'b0;
    end else if (clr | step) begin
      r_count <= TOP;
      r_tick  <= step;
    end else begin
      r_count <= en ? r_count - W'(1) : r_count;
      r_tick  <= 1'b0;
    end
endmodule

// File: rtl/code_scroller.sv
// code_scroller: rotating/loadable message of 2-bit character codes feeding the HEX decoders.
module code_scroller
  import code_pkg::*;
#(
  parameter int TICKS      = 50_000_000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    load,
  input  logic [1:0]              load_code,
  output logic [2*NUM_DIGITS-1:0] codes,
  output logic                    tick
);
  localparam int M = 2 * NUM_DIGITS;
  localparam logic [2*MAX_DIGITS-1:0] RST_ALL = reset_msg(NUM_DIGITS);
  localparam logic [M-1:0] RST_MSG = RST_ALL[M-1:0];
  logic [M-1:0] r_codes;
  logic [M-1:0] w_next;
  logic         w_step;
  rate_divider #(.TICKS(TICKS)) u_div (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .en      (en),
    .clr     (load),
    .tick    (tick),
    .step    (w_step)
  );
  // load wins over a due step; dir=0 moves text toward higher HEX index
  always_comb
    w_next = load   ? {r_codes[M-3:0], load_code} :
             !w_step ? r_codes :
             dir    ? {r_codes[1:0], r_codes[M-1:2]} :
                      {r_codes[M-3:0], r_codes[M-1:M-2]};
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) r_codes <= RST_MSG;
    else         r_codes <= w_next;
  assign codes = r_codes;
endmodule

// File: tb/tb_code_scroller.sv
// tb_code_scroller: directed and random checks of code_scroller against a digit-array model.
module tb_code_scroller;
  localparam int TICKS = 4;
  localparam int N = 6;
  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b1;
  logic          en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [1:0]    load_code = 2'b00;
  logic [2*N-1:0] codes;
  logic          tick;
  int n_tests = 0, n_fail = 0;
  int md[N];
  int mcnt;
  bit mtick;

  code_scroller #(.TICKS(TICKS), .NUM_DIGITS(N)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .en(en), .dir(dir),
    .load(load), .load_code(load_code), .codes(codes), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mpack();
    logic [11:0] p;
    for (int i = 0; i < N; i++) p[2*i +: 2] = 2'(md[i]);
    return p;
  endfunction

  task automatic mreset();
    md = '{3, 2, 1, 0, 3, 3};
    mcnt = TICKS - 1;
    mtick = 0;
  endtask

  // one edge of the message as the spec describes it, on a plain array of digits
  task automatic mstep(input bit e, input bit d, input bit ld, input int lc);
    int t;
    if (ld) begin
      for (int i = N - 1; i > 0; i--) md[i] = md[i-1];
      md[0] = lc;
      mcnt = TICKS - 1;
      mtick = 0;
    end else if (e && mcnt == 0) begin
      if (!d) begin
        t = md[N-1];
        for (int i = N - 1; i > 0; i--) md[i] = md[i-1];
        md[0] = t;
      end else begin
        t = md[0];
        for (int i = 0; i < N - 1; i++) md[i] = md[i+1];
        md[N-1] = t;
      end
      mcnt = TICKS - 1;
      mtick = 1;
    end else begin
      if (e) mcnt--;
      mtick = 0;
    end
  endtask

  task automatic cyc(input string tag, input bit e, input bit d, input bit ld, input logic [1:0] lc);
    en = e; dir = d; load = ld; load_code = lc;
    @(posedge CLOCK_50);
    mstep(e, d, ld, int'(lc));
    #1;
    chk({tag, "_codes"}, 12'(codes), mpack());
    chk({tag, "_tick"}, {11'b0, tick}, {11'b0, mtick});
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    mreset();
    chk({tag, "_rst_codes"}, 12'(codes), 12'hF1B);
    chk({tag, "_rst_tick"}, {11'b0, tick}, 12'h000);
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  initial begin
    #2;
    // 1: first step on edge TICKS, dir=0
    do_reset("t1");
    for (int k = 0; k < 3; k++) cyc("t1_pre", 1, 0, 0, 2'b00);
    cyc("t1_e4", 1, 0, 0, 2'b00);
    chk("t1_e4_const", 12'(codes), 12'hC6F);
    chk("t1_e4_tick", {11'b0, tick}, 12'h001);
    cyc("t1_e5", 1, 0, 0, 2'b00);
    chk("t1_e5_tick", {11'b0, tick}, 12'h000);
    // 2: dir=1 and full-cycle wrap
    do_reset("t2");
    for (int k = 0; k < 4; k++) cyc("t2_a", 1, 1, 0, 2'b00);
    chk("t2_e4_const", 12'(codes), 12'hFC6);
    for (int k = 0; k < 24; k++) cyc("t2_b", 1, 1, 0, 2'b00);
    chk("t2_wrap_const", 12'(codes), 12'hFC6);
    // 3: pause mid-count and resume
    do_reset("t3");
    for (int k = 0; k < 2; k++) cyc("t3_run", 1, 0, 0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      cyc("t3_pause", 0, 0, 0, 2'b00);
      chk("t3_pause_const", 12'(codes), 12'hF1B);
    end
    cyc("t3_res1", 1, 0, 0, 2'b00);
    chk("t3_res1_tick", {11'b0, tick}, 12'h000);
    cyc("t3_res2", 1, 0, 0, 2'b00);
    chk("t3_res2_tick", {11'b0, tick}, 12'h001);
    // 4: load on edge 3 restarts the divider
    do_reset("t4");
    for (int k = 0; k < 2; k++) cyc("t4_pre", 1, 0, 0, 2'b00);
    cyc("t4_load", 1, 0, 1, 2'b01);
    chk("t4_load_const", 12'(codes), 12'hC6D);
    for (int k = 0; k < 3; k++) cyc("t4_post", 1, 0, 0, 2'b00);
    cyc("t4_tick", 1, 0, 0, 2'b00);
    chk("t4_tick_const", {11'b0, tick}, 12'h001);
    // 5: load coinciding with a due step
    do_reset("t5");
    for (int k = 0; k < 3; k++) cyc("t5_pre", 1, 0, 0, 2'b00);
    cyc("t5_coll", 1, 0, 1, 2'b10);
    chk("t5_coll_const", 12'(codes), 12'hC6E);
    chk("t5_coll_tick", {11'b0, tick}, 12'h000);
    // 6: asynchronous reset mid-count with a changed message
    cyc("t6_pre", 1, 0, 0, 2'b00);
    do_reset("t6");
    for (int k = 0; k < 4; k++) cyc("t6_post", 1, 0, 0, 2'b00);
    chk("t6_e4_const", 12'(codes), 12'hC6F);
    // random traffic, including held loads and occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) == 0) do_reset("rnd");
      cyc("rnd", $urandom_range(9) < 8, 1'($urandom), $urandom_range(9) == 0, 2'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
